// File: rtl/butterfly_arb_pkg.sv
// Shared types and helpers for the butterfly arbiter slice.
package butterfly_arb_pkg;

    localparam int unsigned BF_N = 32;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    // Butterfly operand message {ar,ac,br,bc,wr,wc}.
    typedef struct packed {
        logic [BF_N-1:0] ar;
        logic [BF_N-1:0] ac;
        logic [BF_N-1:0] br;
        logic [BF_N-1:0] bc;
        logic [BF_N-1:0] wr;
        logic [BF_N-1:0] wc;
    } bf_op_t;

    // Butterfly result message {cr,cc,dr,dc}.
    typedef struct packed {
        logic [BF_N-1:0] cr;
        logic [BF_N-1:0] cc;
        logic [BF_N-1:0] dr;
        logic [BF_N-1:0] dc;
    } bf_res_t;

endpackage

// File: rtl/butterfly_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding op.
module butterfly_tag_fifo
    import butterfly_arb_pkg::*;
#(
    parameter  int unsigned W     = 2,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = clog2_min1(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    // Pointer advance with wrap at DEPTH-1, so non-power-of-2 depths work.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full   = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd];
    assign count  = r_count;

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= wrap_inc(r_wr);
            if (w_pop)  r_rd <= wrap_inc(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage; contents are meaningless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/butterfly_arbiter.sv
// Round-robin sharing of one butterfly unit among NREQ requesters, results routed by tag.
module butterfly_arbiter
    import butterfly_arb_pkg::*;
#(
    parameter int unsigned n     = 32,
    parameter int unsigned d     = 16,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        recv_val,
    output logic [NREQ-1:0]        recv_rdy,
    input  logic [NREQ*6*n-1:0]    recv_msg,
    output logic [NREQ-1:0]        send_val,
    input  logic [NREQ-1:0]        send_rdy,
    output logic [4*n-1:0]         send_msg,
    output logic                   bf_recv_val,
    input  logic                   bf_recv_rdy,
    output logic [6*n-1:0]         bf_recv_msg,
    input  logic                   bf_send_val,
    output logic                   bf_send_rdy,
    input  logic [4*n-1:0]         bf_send_msg,
    output logic                   busy
);

    localparam int unsigned TW = clog2_min1(NREQ);
    localparam int unsigned OW = 6 * n;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // d only describes the fixed-point format carried through untouched.
    if (NREQ < 1 || DEPTH < 1 || d >= n) begin : g_param_check
        $error("butterfly_arbiter: invalid parameter set");
    end

    logic [TW-1:0] r_ptr;
    logic [TW-1:0] w_grant;
    logic [TW-1:0] w_idx;
    logic [TW-1:0] w_head;
    logic [CW-1:0] w_count;
    logic          w_any;
    logic          w_full;
    logic          w_empty;
    logic          w_issue;
    logic          w_pop;
    logic          w_ret_val;
    logic          w_head_rdy;

    assign w_any       = |recv_val;
    assign bf_recv_val = reset & w_any & ~w_full;
    assign w_issue     = bf_recv_val & bf_recv_rdy;
    assign w_ret_val   = reset & bf_send_val & ~w_empty;
    assign bf_send_rdy = reset & ~w_empty & w_head_rdy;
    assign w_pop       = bf_send_val & bf_send_rdy;
    assign send_msg    = bf_send_msg;
    assign busy        = reset & (w_count != '0);

    // Rotate-priority search starting at r_ptr; the last hit in the reversed scan is the nearest.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            w_idx = TW'((int'(r_ptr) + k) % int'(NREQ));
            if (recv_val[w_idx]) w_grant = w_idx;
        end
    end

    // Operand mux and one-hot ready back to the granted requester only.
    always_comb begin
        bf_recv_msg = '0;
        recv_rdy    = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_any && w_grant == TW'(i)) begin
                bf_recv_msg = recv_msg[i*OW +: OW];
                recv_rdy[i] = w_issue;
            end
        end
    end

    // Result demux: only the head tag's requester sees valid, and only its ready counts.
    always_comb begin
        send_val   = '0;
        w_head_rdy = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_head == TW'(i)) begin
                send_val[i] = w_ret_val;
                w_head_rdy  = send_rdy[i];
            end
        end
    end

    // Priority pointer moves past the winner only when an op actually issues.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_grant == TW'(NREQ - 1)) ? '0 : w_grant + TW'(1);
        end
    end

    butterfly_tag_fifo #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_issue),
        .pop   (w_pop),
        .din   (w_grant),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

endmodule

// File: tb/tb_butterfly_arbiter.sv
// Bench for butterfly_arbiter with a 3-cycle in-order butterfly model and a tag scoreboard.
module tb_butterfly_arbiter;
    import butterfly_arb_pkg::*;

    localparam int unsigned N     = BF_N;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OW    = 6 * N;
    localparam int unsigned RW    = 4 * N;
    localparam int          LAT   = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      recv_val, recv_rdy, send_val, send_rdy;
    logic [NREQ*OW-1:0]   recv_msg;
    logic [RW-1:0]        send_msg;
    logic                 bf_recv_val, bf_recv_rdy, bf_send_val, bf_send_rdy, busy;
    logic [OW-1:0]        bf_recv_msg;
    logic [RW-1:0]        bf_send_msg;

    always #5 clk = ~clk;

    butterfly_arbiter #(.n(N), .d(16), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .bf_recv_val(bf_recv_val), .bf_recv_rdy(bf_recv_rdy), .bf_recv_msg(bf_recv_msg),
        .bf_send_val(bf_send_val), .bf_send_rdy(bf_send_rdy), .bf_send_msg(bf_send_msg),
        .busy(busy)
    );

    typedef struct { int tag; bf_res_t res; } sb_t;
    typedef struct { bf_res_t res; int due; } bfq_t;
    typedef struct {
        logic [NREQ-1:0] rv;
        logic            bf_rdy;
        logic [NREQ-1:0] exp_rrdy;
        logic            exp_bfval;
    } vec_t;

    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;
    int        serial  = 0;
    int        m_ptr   = 0;
    sb_t       sb[$];
    bfq_t      bfq[$];
    int        iss_log[$];
    int        dlv_tag[$];
    bf_res_t   dlv_res[$];
    logic [NREQ-1:0] acc_mask;
    logic [NREQ-1:0] s_recv_rdy, s_send_val;
    logic      s_bf_recv_val, s_bf_send_rdy, s_busy, s_bf_send_val;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Reference butterfly in Q16: c = a + w*b, d = a - w*b.
    function automatic bf_res_t bfly(input bf_op_t op);
        longint  tr, ti;
        bf_res_t r;
        tr = (longint'($signed(op.wr)) * longint'($signed(op.br))
            - longint'($signed(op.wc)) * longint'($signed(op.bc))) >>> 16;
        ti = (longint'($signed(op.wr)) * longint'($signed(op.bc))
            + longint'($signed(op.wc)) * longint'($signed(op.br))) >>> 16;
        r.cr = op.ar + 32'(tr);
        r.cc = op.ac + 32'(ti);
        r.dr = op.ar - 32'(tr);
        r.dc = op.ac - 32'(ti);
        return r;
    endfunction

    function automatic bf_op_t make_op(input int req, input int k);
        bf_op_t o;
        o.ar = 32'((req + 1) << 16) + 32'(k);
        o.ac = 32'(k * 3);
        o.br = 32'h0000_8000 + 32'(req);
        o.bc = 32'(k);
        o.wr = 32'h0001_0000;
        o.wc = 32'(req * 7);
        return o;
    endfunction

    task automatic set_msg(input int req, input bf_op_t op);
        recv_msg[req*OW +: OW] = op;
    endtask

    // Negedge: compare DUT against the reference and record handshakes.
    task automatic observe();
        logic            any, full, empty, e_bfval, e_issue, e_bfsrdy, e_pop, e_busy;
        logic [NREQ-1:0] e_rrdy, e_sval;
        logic [OW-1:0]   e_msg;
        bf_op_t          gop, dop;
        int              eg, h, gi;
        s_recv_rdy    = recv_rdy;
        s_send_val    = send_val;
        s_bf_recv_val = bf_recv_val;
        s_bf_send_rdy = bf_send_rdy;
        s_busy        = busy;
        s_bf_send_val = bf_send_val;
        any   = |recv_val;
        full  = (sb.size() == DEPTH);
        empty = (sb.size() == 0);
        eg = 0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (recv_val[2'((m_ptr + k) % NREQ)]) eg = (m_ptr + k) % NREQ;
        h = empty ? 0 : sb[0].tag;
        gop = recv_msg[eg*OW +: OW];
        e_bfval = 0; e_issue = 0; e_rrdy = '0; e_sval = '0;
        e_bfsrdy = 0; e_pop = 0; e_busy = 0; e_msg = '0;
        if (reset) begin
            e_bfval  = any & !full;
            e_issue  = e_bfval & bf_recv_rdy;
            e_rrdy   = e_issue ? NREQ'(1 << eg) : '0;
            e_sval   = (!empty && bf_send_val) ? NREQ'(1 << h) : '0;
            e_bfsrdy = !empty && send_rdy[2'(h)];
            e_pop    = e_bfsrdy && bf_send_val;
            e_busy   = !empty;
            e_msg    = any ? gop : '0;
            check("bf_recv_msg", bf_recv_msg, e_msg);
        end
        check("handshake", {s_recv_rdy, s_bf_recv_val, s_bf_send_rdy, s_send_val, s_busy},
              {e_rrdy, e_bfval, e_bfsrdy, e_sval, e_busy});
        if (e_pop) begin
            check("send_msg", send_msg, sb[0].res);
            void'(sb.pop_front());
        end
        if (e_issue) begin
            sb.push_back('{tag: eg, res: bfly(gop)});
            m_ptr = (eg + 1) % NREQ;
        end
        if (!reset) begin
            sb.delete();
            m_ptr = 0;
        end
        // Environment side, driven by what the DUT actually did.
        acc_mask = recv_val & recv_rdy;
        if (bf_recv_val && bf_recv_rdy) begin
            dop = bf_recv_msg;
            bfq.push_back('{res: bfly(dop), due: cyc + LAT});
            gi = -1;
            for (int i = 0; i < NREQ; i++) if (recv_rdy[i]) gi = i;
            iss_log.push_back(gi);
        end
        if (bf_send_val && bf_send_rdy && bfq.size() > 0) void'(bfq.pop_front());
        for (int i = 0; i < NREQ; i++) begin
            if (send_val[i] && send_rdy[i]) begin
                dlv_tag.push_back(i);
                dlv_res.push_back(send_msg);
            end
        end
    endtask

    // Just after posedge: advance butterfly model and refresh accepted operands.
    task automatic commit();
        cyc++;
        if (!reset) bfq.delete();
        for (int i = 0; i < NREQ; i++) begin
            if (acc_mask[i]) begin
                set_msg(i, make_op(i, serial));
                serial++;
            end
        end
        bf_send_val = 1'b0;
        bf_send_msg = '0;
        if (bfq.size() > 0) begin
            if (bfq[0].due <= cyc) begin
                bf_send_val = 1'b1;
                bf_send_msg = bfq[0].res;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        recv_val = '0;
        tick();
        reset = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        int c;
        c = 0;
        while ((sb.size() != 0 || bfq.size() != 0) && c < max_cyc) begin
            tick();
            c++;
        end
        check("drain_timeout", 32'(c >= max_cyc), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t   tbl[10];
        int     cnt[NREQ];
        int     c;
        bf_op_t op;
        bf_res_t exp_res;

        reset = 1'b0; recv_val = '0; send_rdy = '1; bf_recv_rdy = 1'b1;
        bf_send_val = 1'b0; bf_send_msg = '0; recv_msg = '0; acc_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            set_msg(i, make_op(i, serial));
            serial++;
        end

        // Reset holds everything quiet even with all requesters valid.
        recv_val = 4'b1111;
        repeat (2) begin
            tick();
            check("reset_outputs", {s_recv_rdy, s_bf_recv_val, s_send_val, s_busy}, '0);
        end
        reset = 1'b1;
        recv_val = '0;

        // Fairness: 8 consecutive issues, 0,1,2,3,0,1,2,3.
        do_reset();
        iss_log.delete();
        recv_val = 4'b1111;
        repeat (8) tick();
        recv_val = '0;
        check("fair_issue_count", 32'(iss_log.size()), 32'd8);
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int j = 0; j < iss_log.size(); j++) begin
            check("fair_order", 32'(iss_log[j]), 32'(j % NREQ));
            if (iss_log[j] >= 0 && iss_log[j] < NREQ) cnt[iss_log[j]]++;
        end
        for (int i = 0; i < NREQ; i++) check("fair_share", 32'(cnt[i]), 32'd2);
        drain(40);

        // Table of grant vectors starting from ptr=0.
        tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b1};
        tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        tbl[2] = '{4'b1001, 1'b1, 4'b1000, 1'b1};
        tbl[3] = '{4'b0110, 1'b0, 4'b0000, 1'b1};
        tbl[4] = '{4'b0110, 1'b1, 4'b0010, 1'b1};
        tbl[5] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
        tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b0};
        tbl[7] = '{4'b1100, 1'b1, 4'b0100, 1'b1};
        tbl[8] = '{4'b0101, 1'b1, 4'b0001, 1'b1};
        tbl[9] = '{4'b1111, 1'b1, 4'b0010, 1'b1};
        do_reset();
        for (int j = 0; j < 10; j++) begin
            recv_val    = tbl[j].rv;
            bf_recv_rdy = tbl[j].bf_rdy;
            tick();
            check("tbl_recv_rdy", s_recv_rdy, tbl[j].exp_rrdy);
            check("tbl_bf_recv_val", s_bf_recv_val, tbl[j].exp_bfval);
        end
        recv_val = '0;
        bf_recv_rdy = 1'b1;
        drain(40);

        // Routing: requester 2, a=1.0, w=1.0, rest 0.
        op = '0;
        op.ar = 32'h0001_0000;
        op.wr = 32'h0001_0000;
        set_msg(2, op);
        dlv_tag.delete(); dlv_res.delete();
        recv_val = 4'b0100;
        tick();
        check("route_issue", s_recv_rdy, 4'b0100);
        recv_val = '0;
        drain(40);
        check("route_count", 32'(dlv_tag.size()), 32'd1);
        if (dlv_tag.size() > 0) begin
            check("route_tag", 32'(dlv_tag[0]), 32'd2);
            check("route_cr", dlv_res[0].cr, 32'h0001_0000);
        end

        // Full: stall returns, only 4 of the 5 requests issue.
        do_reset();
        iss_log.delete();
        send_rdy = '0;
        recv_val = 4'b1111;
        repeat (4) tick();
        check("full_issued4", 32'(iss_log.size()), 32'd4);
        repeat (2) begin
            tick();
            check("full_stall", {s_recv_rdy, s_bf_recv_val, s_busy}, {4'b0000, 1'b0, 1'b1});
        end
        send_rdy = 4'b0001;
        tick();
        check("full_pop", {s_send_val, s_bf_send_rdy, s_recv_rdy}, {4'b0001, 1'b1, 4'b0000});
        send_rdy = '0;
        tick();
        check("full_fifth", s_recv_rdy, 4'b0001);
        check("full_issued5", 32'(iss_log.size()), 32'd5);
        recv_val = '0;
        send_rdy = '1;
        drain(40);

        // Backpressure: head (req 1) not ready, req 3 ready but gets nothing.
        do_reset();
        send_rdy = 4'b1000;
        recv_val = 4'b0010;
        tick();
        recv_val = 4'b1000;
        tick();
        recv_val = '0;
        dlv_tag.delete(); dlv_res.delete();
        repeat (5) begin
            tick();
            check("bp_bf_send_rdy", s_bf_send_rdy, 1'b0);
            check("bp_send_val", s_send_val, s_bf_send_val ? 4'b0010 : 4'b0000);
        end
        check("bp_no_delivery", 32'(dlv_tag.size()), 32'd0);
        check("bp_busy", s_busy, 1'b1);
        send_rdy = '1;
        drain(40);
        check("bp_drain_count", 32'(dlv_tag.size()), 32'd2);
        if (dlv_tag.size() == 2) begin
            check("bp_order0", 32'(dlv_tag[0]), 32'd1);
            check("bp_order1", 32'(dlv_tag[1]), 32'd3);
        end

        // Wrap: 10 ops push rd/wr around the 4-entry FIFO more than twice.
        do_reset();
        iss_log.delete(); dlv_tag.delete(); dlv_res.delete();
        recv_val = 4'b1111;
        c = 0;
        while (iss_log.size() < 10 && c < 40) begin
            tick();
            c++;
        end
        recv_val = '0;
        check("wrap_issue_timeout", 32'(c >= 40), 32'd0);
        drain(40);
        check("wrap_count", 32'(dlv_tag.size()), 32'd10);
        for (int j = 0; j < dlv_tag.size(); j++) check("wrap_tag", 32'(dlv_tag[j]), 32'(j % NREQ));

        // Reset with three ops in flight, then a fresh op routes correctly.
        send_rdy = '0;
        recv_val = 4'b1111;
        repeat (3) tick();
        recv_val = '0;
        tick();
        check("midrst_busy_before", s_busy, 1'b1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("midrst_busy_after", s_busy, 1'b0);
        send_rdy = '1;
        op = make_op(1, 999);
        exp_res = bfly(op);
        set_msg(1, op);
        dlv_tag.delete(); dlv_res.delete();
        recv_val = 4'b0010;
        tick();
        check("midrst_issue", s_recv_rdy, 4'b0010);
        recv_val = '0;
        drain(40);
        check("midrst_count", 32'(dlv_tag.size()), 32'd1);
        if (dlv_tag.size() > 0) begin
            check("midrst_tag", 32'(dlv_tag[0]), 32'd1);
            check("midrst_res", dlv_res[0], exp_res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
